stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the stopwatch timekeeping datapath. It synchronises and debounces the three front-panel controls (start/stop, hold, adjust), runs the run/lap/adjust state machine, and drives the BCD time counter's step, clear and adjust-step strobes, the display freeze latch, and the status LED. It sits between the raw board inputs plus the 100 Hz prescaler and the counter/seven-segment chain.

## Interface
Parameters:
- DEB_TICKS, 2: consecutive ticks a synchronised button level must differ from its debounced value before the debounced value flips.
- REPEAT_DELAY_TICKS, 50: ticks start_stop must stay pressed in ADJUST before auto-repeat begins.
- REPEAT_PERIOD_TICKS, 10: ticks between auto-repeat adj_step pulses.
- CLEAR_TICKS, 200: ticks hold must stay pressed to force a clear (2 s).

Ports:
- CLK_50MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick_100hz  in  1  one-cycle enable pulse every 10 ms from the prescaler.
- start_stop  in  1  raw button, active-low (idle 1).
- hold  in  1  raw button, active-low (idle 1).
- adjust  in  1  raw slide switch, active-high.
- overflow  in  1  one-cycle pulse from the counter on wrap 59:59.99 -> 00:00.00.
- count_step  out  1  one-cycle pulse: advance the counter by 0.01 s.
- count_clr  out  1  one-cycle pulse: clear the counter to 00:00.00.
- adj_step  out  1  one-cycle pulse: adjust-mode increment.
- freeze  out  1  level: display latch holds its last value.
- led  out  1  level: 1 while in RUN or LAP.
- overflow_flag  out  1  sticky overflow indicator.
- state  out  2  IDLE=0, RUN=1, LAP=2, ADJUST=3.

## Operation
- All three inputs pass through a 2-FF synchroniser. Each has a debouncer that counts ticks only. Its counter clears whenever the synchronised level equals the debounced level.
- Press event = debounced falling edge (1->0) for buttons. The adjust level is debounced the same way and is used as a level.
- hold_cnt counts ticks while debounced hold is pressed and saturates at CLEAR_TICKS. long_clear fires once, when hold_cnt reaches CLEAR_TICKS.
- Event priority, highest first, evaluated every cycle: long_clear, overflow, hold press, start_stop press.
- long_clear in any state: count_clr, go to IDLE, freeze=0, overflow_flag=0.
- overflow in RUN/LAP: go to IDLE, freeze=0, overflow_flag=1. In IDLE/ADJUST it is ignored.
- IDLE:
  - start_stop press -> RUN.
  - hold press -> count_clr and overflow_flag=0.
  - adjust=1 and no other event -> ADJUST.
- RUN:
  - start_stop press -> IDLE.
  - hold press -> LAP with freeze=1.
  - adjust is ignored.
- LAP: counter keeps running.
  - hold press -> RUN with freeze=0.
  - start_stop press -> IDLE with freeze=0.
- ADJUST:
  - start_stop press -> adj_step immediately.
  - While the button stays pressed: after REPEAT_DELAY_TICKS ticks, one adj_step every REPEAT_PERIOD_TICKS ticks.
  - Release stops the repeat and resets the repeat counter.
  - hold press -> count_clr.
  - adjust=0 -> IDLE.
- count_step = tick_100hz AND registered state in {RUN, LAP}.

## Timing
- Reset values: state=IDLE; all pulse outputs, freeze, led and overflow_flag are 0. Debounced button levels reset to 1, debounced adjust to 0, all counters to 0.
- Reset asserted mid-operation returns to these values immediately (asynchronous); no pulse is emitted on release.
- Input to press event: 2 clocks of synchronisation plus DEB_TICKS ticks.
- Every output is registered. Pulses are high for exactly 1 clock, asserted the cycle after the causing event or tick. state/led/freeze update on the same edge.
- count_step for a tick uses the state value before any transition caused in that same cycle.
- Simultaneous start_stop and hold presses: only the hold action occurs; the start_stop press is discarded, not deferred.
- Debounce and repeat counters saturate and never wrap.

## Test plan
- Reset, release, then start_stop low for 0.2 s: state 0->1 after sync+2 ticks; led=1; count_step pulses on every tick; a second press returns to IDLE and count_step stops.
- In RUN, hold pressed briefly: state=2, freeze=1, count_step continues. A second hold press gives state=1, freeze=0.
- In IDLE, hold pressed for 10 s: exactly one count_clr at the press and one more at 200 ticks; state stays 0.
- adjust=1 in IDLE -> state=3. start_stop held 100 ticks: adj_step at the press, then at ticks 50, 60, 70, 80, 90, 100 (7 pulses total); none after release.
- Overflow pulse in RUN: state=0, overflow_flag=1, led=0. A later hold press in IDLE gives count_clr and overflow_flag=0.
- Overflow and long_clear in the same cycle: state=0, overflow_flag=0, one count_clr. Reset asserted mid-RUN: all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Front-panel and counter-chain signals of the stopwatch sequencer.
// master drives the raw controls and tick; slave is the sequencer itself.
interface stopwatch_ctrl_if;
    logic       tick_100hz;
    logic       start_stop;
    logic       hold;
    logic       adjust;
    logic       overflow;
    logic       count_step;
    logic       count_clr;
    logic       adj_step;
    logic       freeze;
    logic       led;
    logic       overflow_flag;
    logic [1:0] state;

    modport master (
        output tick_100hz, start_stop, hold, adjust, overflow,
        input  count_step, count_clr, adj_step, freeze, led, overflow_flag, state
    );

    modport slave (
        input  tick_100hz, start_stop, hold, adjust, overflow,
        output count_step, count_clr, adj_step, freeze, led, overflow_flag, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button sync/debounce, run/lap/adjust FSM,
// auto-repeat and long-press clear, driving counter strobes and display freeze.
module stopwatch_ctrl #(
    parameter int DEB_TICKS           = 2,
    parameter int REPEAT_DELAY_TICKS  = 50,
    parameter int REPEAT_PERIOD_TICKS = 10,
    parameter int CLEAR_TICKS         = 200
) (
    input  logic             CLK_50MHz,
    input  logic             reset,
    stopwatch_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAP    = 2'd2,
        ADJUST = 2'd3
    } state_t;

    localparam int DW   = $clog2(DEB_TICKS + 1);
    localparam int CW   = $clog2(CLEAR_TICKS + 1);
    localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ? REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
    localparam int RW   = $clog2(RMAX + 1);

    // Bit 0 start_stop, bit 1 hold (both active-low), bit 2 adjust (active-high).
    localparam logic [2:0] IN_IDLE = 3'b011;

    logic [2:0]    raw_s;
    logic [2:0]    sync1_r;
    logic [2:0]    sync2_r;
    logic [2:0]    deb_r;
    logic [1:0]    deb_d_r;
    logic [DW-1:0] deb_cnt_r [3];
    logic [CW-1:0] hold_cnt_r;
    logic [RW-1:0] rep_cnt_r;
    logic          rep_armed_r;
    logic [RW-1:0] rep_last_s;

    logic ss_press_s, hold_press_s, ss_down_s, hold_down_s, adj_lvl_s;
    logic long_clear_s, rep_fire_s, running_s;

    state_t state_r;
    logic   count_step_r, count_clr_r, adj_step_r, freeze_r, led_r, overflow_flag_r;

    assign raw_s = {bus.adjust, bus.hold, bus.start_stop};

    // Two-flop synchroniser for all three front-panel inputs.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            sync1_r <= IN_IDLE;
            sync2_r <= IN_IDLE;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Tick-based debouncers; a counter only runs while the level disagrees.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            deb_r   <= IN_IDLE;
            deb_d_r <= 2'b11;
            for (int i = 0; i < 3; i++) deb_cnt_r[i] <= {DW{1'b0}};
        end else begin
            deb_d_r <= deb_r[1:0];
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= {DW{1'b0}};
                end else if (bus.tick_100hz) begin
                    if (deb_cnt_r[i] >= DW'(DEB_TICKS - 1)) begin
                        deb_r[i]     <= sync2_r[i];
                        deb_cnt_r[i] <= {DW{1'b0}};
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                    end
                end
            end
        end
    end

    assign ss_press_s   = deb_d_r[0] & ~deb_r[0];
    assign hold_press_s = deb_d_r[1] & ~deb_r[1];
    assign ss_down_s    = ~deb_r[0];
    assign hold_down_s  = ~deb_r[1];
    assign adj_lvl_s    = deb_r[2];
    assign running_s    = (state_r == RUN) || (state_r == LAP);

    // The one-shot fires on the tick that brings the count to CLEAR_TICKS.
    assign long_clear_s = hold_down_s & bus.tick_100hz & (hold_cnt_r == CW'(CLEAR_TICKS - 1));

    // Long-press timer for hold, saturating at CLEAR_TICKS.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            hold_cnt_r <= {CW{1'b0}};
        end else if (!hold_down_s) begin
            hold_cnt_r <= {CW{1'b0}};
        end else if (bus.tick_100hz && (hold_cnt_r != CW'(CLEAR_TICKS))) begin
            hold_cnt_r <= hold_cnt_r + CW'(1);
        end
    end

    assign rep_last_s = rep_armed_r ? RW'(REPEAT_PERIOD_TICKS - 1) : RW'(REPEAT_DELAY_TICKS - 1);
    assign rep_fire_s = (state_r == ADJUST) & ss_down_s & bus.tick_100hz & (rep_cnt_r == rep_last_s);

    // Auto-repeat timer: initial delay first, then the shorter period.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            rep_cnt_r   <= {RW{1'b0}};
            rep_armed_r <= 1'b0;
        end else if ((state_r != ADJUST) || !ss_down_s) begin
            rep_cnt_r   <= {RW{1'b0}};
            rep_armed_r <= 1'b0;
        end else if (bus.tick_100hz) begin
            if (rep_cnt_r == rep_last_s) begin
                rep_cnt_r   <= {RW{1'b0}};
                rep_armed_r <= 1'b1;
            end else begin
                rep_cnt_r <= rep_cnt_r + RW'(1);
            end
        end
    end

    // Main sequencer with registered strobes and levels.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            count_step_r    <= 1'b0;
            count_clr_r     <= 1'b0;
            adj_step_r      <= 1'b0;
            freeze_r        <= 1'b0;
            led_r           <= 1'b0;
            overflow_flag_r <= 1'b0;
        end else begin
            count_step_r <= bus.tick_100hz & running_s;
            count_clr_r  <= 1'b0;
            adj_step_r   <= 1'b0;
            if (long_clear_s) begin
                count_clr_r     <= 1'b1;
                state_r         <= IDLE;
                freeze_r        <= 1'b0;
                led_r           <= 1'b0;
                overflow_flag_r <= 1'b0;
            end else if (bus.overflow && running_s) begin
                state_r         <= IDLE;
                freeze_r        <= 1'b0;
                led_r           <= 1'b0;
                overflow_flag_r <= 1'b1;
            end else begin
                // Hold is tested before start_stop so a simultaneous start_stop press is dropped.
                case (state_r)
                    IDLE: begin
                        if (hold_press_s) begin
                            count_clr_r     <= 1'b1;
                            overflow_flag_r <= 1'b0;
                        end else if (ss_press_s) begin
                            state_r <= RUN;
                            led_r   <= 1'b1;
                        end else if (adj_lvl_s) begin
                            state_r <= ADJUST;
                        end
                    end
                    RUN: begin
                        if (hold_press_s) begin
                            state_r  <= LAP;
                            freeze_r <= 1'b1;
                        end else if (ss_press_s) begin
                            state_r <= IDLE;
                            led_r   <= 1'b0;
                        end
                    end
                    LAP: begin
                        if (hold_press_s) begin
                            state_r  <= RUN;
                            freeze_r <= 1'b0;
                        end else if (ss_press_s) begin
                            state_r  <= IDLE;
                            freeze_r <= 1'b0;
                            led_r    <= 1'b0;
                        end
                    end
                    ADJUST: begin
                        if (hold_press_s) begin
                            count_clr_r <= 1'b1;
                        end else if (ss_press_s) begin
                            adj_step_r <= 1'b1;
                        end else if (!adj_lvl_s) begin
                            state_r <= IDLE;
                        end else if (rep_fire_s) begin
                            adj_step_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        freeze_r <= 1'b0;
                        led_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.state         = state_r;
    assign bus.count_step    = count_step_r;
    assign bus.count_clr     = count_clr_r;
    assign bus.adj_step      = adj_step_r;
    assign bus.freeze        = freeze_r;
    assign bus.led           = led_r;
    assign bus.overflow_flag = overflow_flag_r;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl; the tick prescaler is shortened to
// one tick every TICK_DIV clocks so multi-second scenarios stay short.
module tb_stopwatch_ctrl;
    localparam int TICK_DIV = 4;

    logic clk;
    logic rst;
    stopwatch_ctrl_if bus ();

    stopwatch_ctrl dut (
        .CLK_50MHz (clk),
        .reset     (rst),
        .bus       (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int tick_cnt    = 0;
    int tdiv        = 0;
    int exp_q[$];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        bus.tick_100hz = 1'b0;
        forever begin
            @(negedge clk);
            tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
            bus.tick_100hz = (tdiv == 0);
        end
    end

    always @(posedge clk) begin
        if (bus.tick_100hz === 1'b1) tick_cnt <= tick_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        int t0;
        t0 = tick_cnt;
        while (tick_cnt - t0 < n) @(negedge clk);
    endtask

    // Returns on the negedge just after a tick edge, giving a fixed phase.
    task automatic align_tick();
        int t0;
        @(negedge clk);
        t0 = tick_cnt;
        while (tick_cnt == t0) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int maxc, output int cycles);
        cycles = 0;
        while (bus.state !== s && cycles < maxc) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        vectors++;
        if ({bus.count_step, bus.count_clr, bus.adj_step, bus.freeze, bus.led, bus.overflow_flag} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000", {bus.count_step, bus.count_clr, bus.adj_step, bus.freeze, bus.led, bus.overflow_flag});
        end
        vectors++;
        if (bus.state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        rst = 1'b0;
        cyc(20);
        vectors++;
        if ({bus.state, bus.count_clr, bus.adj_step, bus.led} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected 00000", {bus.state, bus.count_clr, bus.adj_step, bus.led});
        end
    endtask

    task automatic test_run();
        int c, t0, ts, steps;
        align_tick();
        bus.start_stop = 1'b0;
        t0 = tick_cnt;
        wait_state(2'd1, 60, c);
        vectors++;
        if (bus.state !== 2'd1) begin miscompares++; $display("FAIL run_state: got %0d expected 1", bus.state); end
        vectors++;
        if (c != 9) begin miscompares++; $display("FAIL run_latency_clk: got %0d expected 9", c); end
        vectors++;
        if (tick_cnt - t0 != 2) begin miscompares++; $display("FAIL run_latency_ticks: got %0d expected 2", tick_cnt - t0); end
        vectors++;
        if (bus.led !== 1'b1) begin miscompares++; $display("FAIL run_led: got %b expected 1", bus.led); end
        ts = tick_cnt; steps = 0;
        repeat (40) begin @(negedge clk); if (bus.count_step === 1'b1) steps++; end
        vectors++;
        if (steps != tick_cnt - ts || steps == 0) begin miscompares++; $display("FAIL run_steps: got %0d expected %0d", steps, tick_cnt - ts); end
        while (tick_cnt - t0 < 20) @(negedge clk);
        bus.start_stop = 1'b1;
        wait_ticks(5);
        bus.start_stop = 1'b0;
        wait_state(2'd0, 60, c);
        vectors++;
        if (bus.state !== 2'd0 || bus.led !== 1'b0) begin miscompares++; $display("FAIL stop_state: got state %0d led %b expected 0 0", bus.state, bus.led); end
        bus.start_stop = 1'b1;
        wait_ticks(4);
        steps = 0;
        repeat (40) begin @(negedge clk); if (bus.count_step === 1'b1) steps++; end
        vectors++;
        if (steps != 0) begin miscompares++; $display("FAIL idle_steps: got %0d expected 0", steps); end
    endtask

    task automatic press(input bit is_hold, input logic [1:0] target);
        int c;
        align_tick();
        if (is_hold) bus.hold = 1'b0; else bus.start_stop = 1'b0;
        wait_state(target, 60, c);
        bus.hold = 1'b1;
        bus.start_stop = 1'b1;
    endtask

    task automatic test_lap();
        int ts, steps;
        press(1'b0, 2'd1);
        wait_ticks(5);
        press(1'b1, 2'd2);
        vectors++;
        if ({bus.state, bus.freeze, bus.led} !== 4'b1011) begin miscompares++; $display("FAIL lap_enter: got %b expected 1011", {bus.state, bus.freeze, bus.led}); end
        wait_ticks(4);
        ts = tick_cnt; steps = 0;
        repeat (40) begin @(negedge clk); if (bus.count_step === 1'b1) steps++; end
        vectors++;
        if (steps != tick_cnt - ts || steps == 0) begin miscompares++; $display("FAIL lap_steps: got %0d expected %0d", steps, tick_cnt - ts); end
        press(1'b1, 2'd1);
        vectors++;
        if ({bus.state, bus.freeze} !== 3'b010) begin miscompares++; $display("FAIL lap_exit: got %b expected 010", {bus.state, bus.freeze}); end
        wait_ticks(5);
        press(1'b1, 2'd2);
        wait_ticks(5);
        press(1'b0, 2'd0);
        vectors++;
        if ({bus.state, bus.freeze, bus.led} !== 4'b0000) begin miscompares++; $display("FAIL lap_stop: got %b expected 0000", {bus.state, bus.freeze, bus.led}); end
        wait_ticks(5);
    endtask

    task automatic test_long_clear();
        int t0, bad, e;
        align_tick();
        bus.hold = 1'b0;
        t0 = tick_cnt;
        bad = 0;
        exp_q.push_back(2);
        exp_q.push_back(2 + 200);
        while (tick_cnt - t0 < 1000 + 10) begin
            @(negedge clk);
            if (tick_cnt - t0 >= 1000) bus.hold = 1'b1;
            if (bus.state !== 2'd0) bad++;
            if (bus.count_clr === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL clear_extra: got pulse at tick %0d expected none", tick_cnt - t0);
                end else begin
                    e = exp_q.pop_front();
                    if (tick_cnt - t0 != e) begin miscompares++; $display("FAIL clear_time: got tick %0d expected %0d", tick_cnt - t0, e); end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL clear_count: got %0d missing expected 0", exp_q.size()); end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL clear_state: got %0d non-idle cycles expected 0", bad); end
        exp_q.delete();
    endtask

    task automatic test_adjust();
        int c, t0, e;
        bus.adjust = 1'b1;
        wait_state(2'd3, 60, c);
        vectors++;
        if (bus.state !== 2'd3) begin miscompares++; $display("FAIL adj_enter: got %0d expected 3", bus.state); end
        align_tick();
        bus.start_stop = 1'b0;
        t0 = tick_cnt;
        exp_q.push_back(2);
        for (int k = 50; k <= 100; k += 10) exp_q.push_back(2 + k);
        while (tick_cnt - t0 < 130) begin
            @(negedge clk);
            if (bus.adj_step === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL adj_extra: got pulse at tick %0d expected none", tick_cnt - t0);
                end else begin
                    e = exp_q.pop_front();
                    if (tick_cnt - t0 != e) begin miscompares++; $display("FAIL adj_time: got tick %0d expected %0d", tick_cnt - t0, e); end
                end
            end
            if (tick_cnt - t0 >= 102) bus.start_stop = 1'b1;
        end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL adj_count: got %0d missing expected 0", exp_q.size()); end
        exp_q.delete();
        bus.adjust = 1'b0;
        wait_state(2'd0, 60, c);
        vectors++;
        if (bus.state !== 2'd0) begin miscompares++; $display("FAIL adj_exit: got %0d expected 0", bus.state); end
    endtask

    task automatic test_overflow();
        int clrs;
        press(1'b0, 2'd1);
        wait_ticks(5);
        @(negedge clk);
        bus.overflow = 1'b1;
        @(negedge clk);
        bus.overflow = 1'b0;
        vectors++;
        if ({bus.state, bus.overflow_flag, bus.led} !== 4'b0010) begin miscompares++; $display("FAIL ovf_run: got %b expected 0010", {bus.state, bus.overflow_flag, bus.led}); end
        align_tick();
        bus.hold = 1'b0;
        clrs = 0;
        repeat (60) begin @(negedge clk); if (bus.count_clr === 1'b1) clrs++; end
        bus.hold = 1'b1;
        vectors++;
        if (clrs != 1) begin miscompares++; $display("FAIL ovf_clr_count: got %0d expected 1", clrs); end
        vectors++;
        if (bus.overflow_flag !== 1'b0) begin miscompares++; $display("FAIL ovf_flag_clear: got %b expected 0", bus.overflow_flag); end
        wait_ticks(5);
    endtask

    task automatic test_ovf_and_clear();
        int c, t0, clrs;
        press(1'b0, 2'd1);
        wait_ticks(5);
        align_tick();
        bus.hold = 1'b0;
        wait_state(2'd2, 60, c);
        t0 = tick_cnt;
        clrs = 0;
        while (tick_cnt != t0 + 199) begin @(negedge clk); if (bus.count_clr === 1'b1) clrs++; end
        cyc(3);
        bus.overflow = 1'b1;
        @(negedge clk);
        bus.overflow = 1'b0;
        vectors++;
        if ({bus.count_clr, bus.state, bus.overflow_flag, bus.led, bus.freeze} !== 6'b100000) begin
            miscompares++; $display("FAIL ovf_clear_same: got %b expected 100000", {bus.count_clr, bus.state, bus.overflow_flag, bus.led, bus.freeze});
        end
        repeat (20) begin @(negedge clk); if (bus.count_clr === 1'b1) clrs++; end
        vectors++;
        if (clrs != 0) begin miscompares++; $display("FAIL ovf_clear_extra: got %0d expected 0", clrs); end
        bus.hold = 1'b1;
        wait_ticks(5);
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        press(1'b0, 2'd1);
        wait_ticks(5);
        press(1'b1, 2'd2);
        wait_ticks(5);
        vectors++;
        if (bus.freeze !== 1'b1 || bus.led !== 1'b1) begin miscompares++; $display("FAIL pre_reset: got freeze %b led %b expected 1 1", bus.freeze, bus.led); end
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.state, bus.freeze, bus.led, bus.count_step, bus.count_clr, bus.adj_step, bus.overflow_flag} !== 8'b0) begin
            miscompares++; $display("FAIL async_reset: got %b expected 00000000", {bus.state, bus.freeze, bus.led, bus.count_step, bus.count_clr, bus.adj_step, bus.overflow_flag});
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.count_step === 1'b1 || bus.count_clr === 1'b1 || bus.adj_step === 1'b1 || bus.state !== 2'd0) pulses++;
        end
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL post_reset: got %0d active cycles expected 0", pulses); end
    endtask

    initial begin
        rst            = 1'b1;
        bus.start_stop = 1'b1;
        bus.hold       = 1'b1;
        bus.adjust     = 1'b0;
        bus.overflow   = 1'b0;
        test_reset();
        test_run();
        test_lap();
        test_long_clear();
        test_adjust();
        test_overflow();
        test_ovf_and_clear();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
